// File: rtl/myproject_mul_share_arb_if.sv
// Handshake bundle between the requester lanes and the shared multiplier:
// per-lane operand valid/ready plus the tagged result stream.
interface myproject_mul_share_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int DIN0_W  = 16,
    parameter int DIN1_W  = 16,
    parameter int DOUT_W  = 26
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DIN0_W-1:0] req_din0;
    logic [NUM_REQ*DIN1_W-1:0] req_din1;
    logic                      res_valid;
    logic                      res_ready;
    logic [DOUT_W-1:0]         res_dout;
    logic [ID_W-1:0]           res_id;

    modport slave (
        input  req_valid, req_din0, req_din1, res_ready,
        output req_ready, res_valid, res_dout, res_id
    );

    modport master (
        output req_valid, req_din0, req_din1, res_ready,
        input  req_ready, res_valid, res_dout, res_id
    );
endinterface

// File: rtl/myproject_mul_share_arb.sv
// One signed multiplier time-shared by NUM_REQ lanes: round-robin grant into an
// operand stage, a registered product stage, results tagged with the lane id.
module myproject_mul_share_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int DIN0_W  = 16,
    parameter int DIN1_W  = 16,
    parameter int DOUT_W  = 26
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    myproject_mul_share_arb_if.slave  bus,
    output logic                      busy
);
    localparam int PROD_W = DIN0_W + DIN1_W;
    localparam int SUM_W  = ID_W + 1;
    localparam logic [SUM_W-1:0] NUM_REQ_S = SUM_W'(NUM_REQ);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);

    logic                     r_s1_v;
    logic signed [DIN0_W-1:0] r_a;
    logic signed [DIN1_W-1:0] r_b;
    logic [ID_W-1:0]          r_s1_id;
    logic                     r_s2_v;
    logic [DOUT_W-1:0]        r_dout;
    logic [ID_W-1:0]          r_s2_id;
    logic [ID_W-1:0]          r_rr_ptr;

    logic                     w_adv1;
    logic                     w_adv2;
    logic                     w_hit;
    logic                     w_accept;
    logic [ID_W-1:0]          w_gnt;
    logic [SUM_W-1:0]         w_sum;
    logic [ID_W-1:0]          w_cand;
    logic [NUM_REQ-1:0]       w_ready;
    logic [ID_W-1:0]          w_rr_next;

    // Full-width signed product wrapped to the low DOUT_W bits (no saturation).
    function automatic logic [DOUT_W-1:0] mul_trunc(
        input logic signed [DIN0_W-1:0] a,
        input logic signed [DIN1_W-1:0] b
    );
        return DOUT_W'(PROD_W'(a) * PROD_W'(b));
    endfunction

    assign w_adv2   = !r_s2_v | bus.res_ready;
    assign w_adv1   = !r_s1_v | w_adv2;
    assign w_accept = w_hit & w_adv1;
    assign w_rr_next = (w_gnt == LAST_ID) ? '0 : w_gnt + ID_W'(1);

    // Round-robin search: first valid lane at or after the pointer, wrapping at NUM_REQ.
    always_comb begin
        w_hit  = 1'b0;
        w_gnt  = '0;
        w_sum  = '0;
        w_cand = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum  = {1'b0, r_rr_ptr} + SUM_W'(k);
            w_sum  = (w_sum >= NUM_REQ_S) ? (w_sum - NUM_REQ_S) : w_sum;
            w_cand = w_sum[ID_W-1:0];
            if (!w_hit && bus.req_valid[w_cand]) begin
                w_hit = 1'b1;
                w_gnt = w_cand;
            end else begin
                w_hit = w_hit;
            end
        end
    end

    // Only the granted lane sees ready, and only when the operand stage can take it.
    always_comb begin
        w_ready = '0;
        if (w_accept) begin
            w_ready[w_gnt] = 1'b1;
        end else begin
            w_ready = '0;
        end
    end

    // Operand stage and round-robin pointer.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_s1_v   <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_s1_id  <= '0;
            r_rr_ptr <= '0;
        end else if (w_adv1) begin
            if (w_accept) begin
                r_s1_v   <= 1'b1;
                r_a      <= bus.req_din0[w_gnt*DIN0_W +: DIN0_W];
                r_b      <= bus.req_din1[w_gnt*DIN1_W +: DIN1_W];
                r_s1_id  <= w_gnt;
                r_rr_ptr <= w_rr_next;
            end else begin
                r_s1_v   <= 1'b0;
            end
        end
    end

    // Product stage; holds its contents while the consumer stalls.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_s2_v  <= 1'b0;
            r_dout  <= '0;
            r_s2_id <= '0;
        end else if (w_adv2) begin
            if (r_s1_v) begin
                r_s2_v  <= 1'b1;
                r_dout  <= mul_trunc(r_a, r_b);
                r_s2_id <= r_s1_id;
            end else begin
                r_s2_v  <= 1'b0;
            end
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.res_valid = r_s2_v;
    assign bus.res_dout  = r_dout;
    assign bus.res_id    = r_s2_id;
    assign busy          = r_s1_v | r_s2_v;

endmodule
